// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle 16-bit-instruction core: opcodes,
// controller states and instruction field positions.
package mips_pkg;

    // Opcodes (instruction bits [15:12]); 0xA-0xE decode as NOP
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field slices
    localparam int unsigned OP_HI = 15;
    localparam int unsigned OP_LO = 12;
    localparam int unsigned RA_HI = 11;
    localparam int unsigned RA_LO = 8;
    localparam int unsigned RB_HI = 7;
    localparam int unsigned RB_LO = 4;
    localparam int unsigned RC_HI = 3;
    localparam int unsigned RC_LO = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/mips_regfile.sv
// 16-entry register file: two async read ports, one debug read port,
// one synchronous write port. r0 reads as zero and ignores writes.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [3:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_raddr_a,
    input  logic [3:0]        i_raddr_b,
    input  logic [3:0]        i_dbg_addr,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [16];

    // Register storage: cleared on reset, written on the edge when enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 4'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == 4'd0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == 4'd0) ? '0 : r_regs[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == 4'd0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB controller with req/ack
// instruction and data memory ports, retired counter and debug read port.
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            r_state;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_retired;
    logic              r_halted;
    logic              r_imem_req;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;

    logic [3:0]        w_op;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [3:0]        w_rc;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_br;
    logic              w_taken;
    logic              w_rf_we;
    logic [3:0]        w_wdest;

    assign w_op   = r_ir[OP_HI:OP_LO];
    assign w_ra   = r_ir[RA_HI:RA_LO];
    assign w_rb   = r_ir[RB_HI:RB_LO];
    assign w_rc   = r_ir[RC_HI:RC_LO];
    assign w_simm = {{(DATA_W-4){r_ir[RC_HI]}}, r_ir[RC_HI:RC_LO]};
    // Shared by ADDI and the load/store effective address
    assign w_sum  = r_a + w_simm;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_pc_br  = w_pc_inc + w_simm[ADDR_W-1:0];
    assign w_taken  = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    // ADDI and LW write rb; register-register ops write rc
    assign w_wdest = ((w_op == OP_ADDI) || (w_op == OP_LW)) ? w_rb : w_rc;
    assign w_rf_we = (r_state == S_WB);

    // ALU result for register-writing operations
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_ADDI: w_alu = w_sum;
            default: w_alu = '0;
        endcase
    end

    mips_regfile #(
        .DATA_W(DATA_W)
    ) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_we       (w_rf_we),
        .i_waddr    (w_wdest),
        .i_wdata    (r_res),
        .i_raddr_a  (w_ra),
        .i_raddr_b  (w_rb),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_dbg_data (dbg_data)
    );

    // Instruction sequencer; requests are raised on the edge entering the
    // state that owns them and dropped on the edge that samples ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_pc         <= '0;
            r_retired    <= '0;
            r_halted     <= 1'b0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Only the first fetch after reset arrives with req low
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= w_rd_a;
                    r_b     <= w_rd_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
                            r_res   <= w_alu;
                            r_state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (w_op == OP_SW);
                            r_dmem_addr  <= w_sum[ADDR_W-1:0];
                            r_dmem_wdata <= r_b;
                            r_state      <= S_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            r_pc       <= w_taken ? w_pc_br : w_pc_inc;
                            r_retired  <= r_retired + CNT_W'(1);
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_pc       <= w_pc_inc;
                            r_retired  <= r_retired + CNT_W'(1);
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_pc       <= w_pc_inc;
                            r_retired  <= r_retired + CNT_W'(1);
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_res   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_pc       <= w_pc_inc;
                    r_retired  <= r_retired + CNT_W'(1);
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign retired    = r_retired;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs run against req/ack
// memory models with configurable wait states.
module tb_mips_multicycle;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack   = 1'b0;
    logic [15:0]       imem_rdata = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack   = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [CNT_W-1:0]  retired;
    logic [3:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    logic [15:0]       imem [65536];
    logic [DATA_W-1:0] dmem [256];
    int                imem_wait;
    int                dmem_wait;
    int                icnt;
    int                dcnt;
    int                n_cmp;
    int                n_err;

    mips_multicycle #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models answer on the falling edge; ack after *_wait req cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dmem[i] = '0;
            dmem[7] = 16'h8000;
        end
        if (!imem_req) begin
            imem_ack = 1'b0;
            icnt     = 0;
        end else begin
            imem_ack   = (icnt == imem_wait);
            imem_rdata = imem[imem_addr];
            icnt++;
        end
        if (!dmem_req) begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end else begin
            dmem_ack   = (dcnt == dmem_wait);
            dmem_rdata = dmem[dmem_addr[7:0]];
            if (dmem_ack && dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
            dcnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 65536; i++) imem[i] = 16'hF000;
    endtask

    task automatic wait_retired(input int n);
        int k = 0;
        while (retired != CNT_W'(n) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("retire_wait", 64'(retired), 64'(n));
    endtask

    task automatic check_reg(input string tag, input logic [3:0] r, input logic [15:0] exp);
        dbg_addr = r;
        #1;
        check_eq(tag, 64'(dbg_data), 64'(exp));
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int n;
        logic stable;
        logic seen;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;

        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        dbg_addr  = '0;
        imem_wait = 0;
        dmem_wait = 0;

        // Phase 1: ALU, store/load with wait states, taken BNE
        fill_imem();
        imem[0] = 16'h5015;   // ADDI r1,r0,5
        imem[1] = 16'h502D;   // ADDI r2,r0,-3
        imem[2] = 16'h0123;   // ADD  r3,r1,r2
        imem[3] = 16'h7014;   // SW   r1,[r0+4]
        imem[4] = 16'h6044;   // LW   r4,[r0+4]
        imem[5] = 16'hA000;   // NOP
        imem[6] = 16'h912E;   // BNE  r1,r2,-2

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pc", 64'(pc), 64'h0);
        check_eq("rst_retired", 64'(retired), 64'h0);
        check_eq("rst_halted", 64'(halted), 64'h0);
        check_eq("rst_imem_req", 64'(imem_req), 64'h0);
        check_eq("rst_dmem_req", 64'(dmem_req), 64'h0);
        check_eq("rst_dmem_we", 64'(dmem_we), 64'h0);
        check_eq("rst_dmem_addr", 64'(dmem_addr), 64'h0);
        check_eq("rst_dmem_wdata", 64'(dmem_wdata), 64'h0);
        check_reg("rst_r1", 4'd1, 16'h0);

        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!imem_req && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("first_req", 64'(imem_req), 64'h1);
        check_eq("first_req_lat", 64'(k), 64'h1);

        repeat (12) @(posedge clk);
        #1;
        check_eq("p1_pc", 64'(pc), 64'h3);
        check_eq("p1_retired", 64'(retired), 64'h3);
        check_reg("p1_r3", 4'd3, 16'h0002);

        dmem_wait = 3;
        k = 0;
        while (!dmem_req && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("sw_req", 64'(dmem_req), 64'h1);
        a0 = dmem_addr;
        d0 = dmem_wdata;
        check_eq("sw_addr", 64'(a0), 64'h4);
        check_eq("sw_wdata", 64'(d0), 64'h5);
        check_eq("sw_we", 64'(dmem_we), 64'h1);
        n = 0;
        stable = 1'b1;
        while (dmem_req && n < 20) begin
            if (dmem_addr !== a0 || dmem_wdata !== d0 || dmem_we !== 1'b1) stable = 1'b0;
            n++;
            @(posedge clk);
            #1;
        end
        check_eq("sw_req_cycles", 64'(n), 64'h4);
        check_eq("sw_stable", 64'(stable), 64'h1);
        check_eq("sw_retired", 64'(retired), 64'h4);
        k = 0;
        while (retired != 5 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("lw_cycles", 64'(k), 64'h8);
        check_reg("lw_r4", 4'd4, 16'h0005);
        dmem_wait = 0;

        wait_retired(7);
        check_eq("bne_taken_pc", 64'(pc), 64'h5);

        // Phase 2: r0 write, SLT signed, BEQ not taken, SUB/AND/OR, HALT
        rst_n = 1'b0;
        #1;
        check_eq("p2_rst_retired", 64'(retired), 64'h0);
        fill_imem();
        imem[0]  = 16'h5017;  // ADDI r1,r0,7
        imem[1]  = 16'h0110;  // ADD  r0,r1,r1
        imem[2]  = 16'h6067;  // LW   r6,[r0+7]
        imem[3]  = 16'h5071;  // ADDI r7,r0,1
        imem[4]  = 16'h4678;  // SLT  r8,r6,r7
        imem[5]  = 16'h4769;  // SLT  r9,r7,r6
        imem[6]  = 16'h8103;  // BEQ  r1,r0,3
        imem[7]  = 16'h117A;  // SUB  r10,r1,r7
        imem[8]  = 16'h217B;  // AND  r11,r1,r7
        imem[9]  = 16'h367C;  // OR   r12,r6,r7
        release_reset();

        wait_retired(1);
        check_reg("r1_7", 4'd1, 16'h0007);
        wait_retired(2);
        check_reg("r0_zero", 4'd0, 16'h0000);
        wait_retired(3);
        check_reg("lw_r6", 4'd6, 16'h8000);
        wait_retired(5);
        check_reg("slt_neg", 4'd8, 16'h0001);
        wait_retired(6);
        check_reg("slt_pos", 4'd9, 16'h0000);
        wait_retired(7);
        check_eq("beq_nt_pc", 64'(pc), 64'h7);
        wait_retired(8);
        check_reg("sub", 4'd10, 16'h0006);
        wait_retired(9);
        check_reg("and", 4'd11, 16'h0001);
        wait_retired(10);
        check_reg("or", 4'd12, 16'h8001);

        k = 0;
        while (!halted && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("halted", 64'(halted), 64'h1);
        check_eq("halt_retired", 64'(retired), 64'd10);
        check_eq("halt_pc", 64'(pc), 64'd10);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (imem_req || dmem_req) seen = 1'b1;
        end
        check_eq("halt_no_req", 64'(seen), 64'h0);
        check_eq("halt_retired_hold", 64'(retired), 64'd10);

        // Phase 3: PC wrap, then reset during a stalled fetch
        rst_n = 1'b0;
        fill_imem();
        imem[0]     = 16'h800E;  // BEQ r0,r0,-2 -> 0xFFFF
        imem[65535] = 16'h8000;  // BEQ r0,r0,0  -> wraps to 0
        release_reset();
        wait_retired(1);
        check_eq("br_to_ffff", 64'(pc), 64'hFFFF);
        check_eq("imem_addr_pc", 64'(imem_addr), 64'hFFFF);
        wait_retired(2);
        check_eq("pc_wrap", 64'(pc), 64'h0);

        imem_wait = 20;
        k = 0;
        while (!imem_req && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #3;
        check_eq("req_waiting", 64'(imem_req), 64'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_drops_req", 64'(imem_req), 64'h0);
        imem_wait = 0;
        release_reset();
        check_eq("rel_pc", 64'(pc), 64'h0);
        check_eq("rel_retired", 64'(retired), 64'h0);
        k = 0;
        while (!imem_req && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("refetch_req", 64'(imem_req), 64'h1);
        check_eq("refetch_addr", 64'(imem_addr), 64'h0);
        wait_retired(1);
        check_eq("refetch_exec", 64'(pc), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
